// File: rtl/lockout_controller_pkg.sv
// Shared types and default parameters for the lockout controller.
// Package name lock_pkg is used by the interface, top and bench.
package lock_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    LOCKED  = 2'd1,
    BLOCKED = 2'd2
  } lock_state_t;

  localparam int DEF_CNT_W       = 3;
  localparam int DEF_LVL_W       = 3;
  localparam int DEF_TIME_W      = 9;
  localparam int DEF_MAX_ERR     = 3;
  localparam int DEF_BASE_LOCK   = 30;
  localparam int DEF_MAX_SHIFT   = 3;
  localparam int DEF_PERMA_LEVEL = 4;

endpackage

// File: rtl/lockout_controller_if.sv
// Event inputs and status outputs of the lockout controller.
// The master side drives the key/code events; the slave side is the controller.
interface lockout_controller_if
  import lock_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LVL_W  = DEF_LVL_W,
  parameter int TIME_W = DEF_TIME_W
) ();

  logic              tick;
  logic              err_in;
  logic              ok_in;
  logic              admin_clear;
  logic              gen_stop;
  logic              blocked;
  logic              lock_start;
  logic [CNT_W-1:0]  error_counter;
  logic [LVL_W-1:0]  lock_level;
  logic [TIME_W-1:0] time_left;

  modport master (
    output tick, err_in, ok_in, admin_clear,
    input  gen_stop, blocked, lock_start, error_counter, lock_level, time_left
  );

  modport slave (
    input  tick, err_in, ok_in, admin_clear,
    output gen_stop, blocked, lock_start, error_counter, lock_level, time_left
  );

endinterface

// File: rtl/lockout_controller_rise_detect.sv
// Rising-edge detector: a held-high input yields a single-cycle event.
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst_in) prev_q <= '0;
    else        prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/lockout_controller.sv
// Attempt-error lockout FSM: counts wrong codes, enforces escalating timed
// lockouts, and falls into a permanent block that only admin_clear releases.
module lockout_controller
  import lock_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_ERR     = DEF_MAX_ERR,
  parameter int BASE_LOCK   = DEF_BASE_LOCK,
  parameter int MAX_SHIFT   = DEF_MAX_SHIFT,
  parameter int PERMA_LEVEL = DEF_PERMA_LEVEL,
  parameter int LVL_W       = DEF_LVL_W,
  parameter int TIME_W      = DEF_TIME_W
) (
  input  logic                 clk,
  input  logic                 rst_in,
  lockout_controller_if.slave  bus
);

  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  if ((BASE_LOCK << MAX_SHIFT) > ((1 << TIME_W) - 1)) begin : g_chk_time
    $error("TIME_W too narrow for BASE_LOCK << MAX_SHIFT");
  end
  if (MAX_ERR < 1 || MAX_ERR > ((1 << CNT_W) - 1)) begin : g_chk_err
    $error("MAX_ERR out of range for CNT_W");
  end
  if (PERMA_LEVEL > ((1 << LVL_W) - 1)) begin : g_chk_lvl
    $error("PERMA_LEVEL out of range for LVL_W");
  end

  logic [2:0] rise;
  logic       clr_ev, ok_ev, err_ev;

  rise_detect #(.WIDTH(3)) u_rise (
    .clk    (clk),
    .rst_in (rst_in),
    .sig_i  ({bus.admin_clear, bus.ok_in, bus.err_in}),
    .rise_o (rise)
  );

  assign clr_ev = rise[2];
  assign ok_ev  = rise[1];
  assign err_ev = rise[0];

  lock_state_t       state_q, state_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              start_q, start_d;

  logic [CNT_W:0]    err_inc;
  logic [LVL_W-1:0]  lvl_inc;
  logic [TIME_W-1:0] lock_len;

  // Lockout length doubles per prior lockout, capped at MAX_SHIFT doublings.
  always_comb begin
    err_inc = {1'b0, err_cnt_q} + (CNT_W+1)'(1);
    lvl_inc = (lvl_q == LVL_MAX) ? lvl_q : lvl_q + LVL_W'(1);
    if (int'(lvl_q) >= MAX_SHIFT) lock_len = TIME_W'(BASE_LOCK) << MAX_SHIFT;
    else                          lock_len = TIME_W'(BASE_LOCK) << lvl_q;
  end

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    lvl_d     = lvl_q;
    time_d    = time_q;
    start_d   = 1'b0;
    if (clr_ev) begin
      state_d   = ARMED;
      err_cnt_d = '0;
      lvl_d     = '0;
      time_d    = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (ok_ev) begin
            err_cnt_d = '0;
            lvl_d     = '0;
          end else if (err_ev) begin
            if (int'(err_inc) < MAX_ERR) begin
              err_cnt_d = err_inc[CNT_W-1:0];
            end else begin
              err_cnt_d = '0;
              lvl_d     = lvl_inc;
              start_d   = 1'b1;
              if (int'(lvl_inc) >= PERMA_LEVEL) begin
                state_d = BLOCKED;
                time_d  = '0;
              end else begin
                state_d = LOCKED;
                time_d  = lock_len;
              end
            end
          end
        end
        LOCKED: begin
          if (bus.tick && time_q != '0) begin
            time_d = time_q - TIME_W'(1);
            if (time_q == TIME_W'(1)) state_d = ARMED;
          end
        end
        BLOCKED: time_d = '0;
        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= ARMED;
      err_cnt_q <= '0;
      lvl_q     <= '0;
      time_q    <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      lvl_q     <= lvl_d;
      time_q    <= time_d;
      start_q   <= start_d;
    end
  end

  assign bus.gen_stop      = (state_q != ARMED);
  assign bus.blocked       = (state_q == BLOCKED);
  assign bus.lock_start    = start_q;
  assign bus.error_counter = err_cnt_q;
  assign bus.lock_level    = lvl_q;
  assign bus.time_left     = time_q;

endmodule

// File: tb/tb_lockout_controller.sv
// Scenario bench for lockout_controller: expected snapshots are queued as
// stimulus is applied and compared once the controller has updated.
module tb_lockout_controller;
  import lock_pkg::*;

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  lockout_controller_if #(.CNT_W(3), .LVL_W(3), .TIME_W(9)) bus ();

  lockout_controller #(
    .CNT_W(3), .MAX_ERR(3), .BASE_LOCK(30), .MAX_SHIFT(3),
    .PERMA_LEVEL(4), .LVL_W(3), .TIME_W(9)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // {gen_stop, blocked, lock_start, error_counter[3], lock_level[3], time_left[9]}
  typedef logic [17:0] obs_t;
  obs_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic obs_t pk(input logic gs, input logic bl, input logic ls,
                              input int ec, input int lvl, input int tl);
    return {gs, bl, ls, 3'(ec), 3'(lvl), 9'(tl)};
  endfunction

  function automatic obs_t sample();
    return {bus.gen_stop, bus.blocked, bus.lock_start,
            bus.error_counter, bus.lock_level, bus.time_left};
  endfunction

  task automatic step(input logic e, input logic o, input logic c, input logic t);
    bus.err_in = e; bus.ok_in = o; bus.admin_clear = c; bus.tick = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_in = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset got=%h want=%h", o, e); end
    rst_in = 1'b0;
  endtask

  task automatic test_count();
    obs_t o, e;
    exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL count_err1 got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 2, 0, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL count_err2 got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL count_ok_clear got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_lockout();
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    exp_q.push_back(pk(1, 0, 1, 0, 1, 30));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock1_entry got=%h want=%h", o, e); end
    exp_q.push_back(pk(1, 0, 0, 0, 1, 30));
    step(0, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock1_hold got=%h want=%h", o, e); end
    exp_q.push_back(pk(1, 0, 0, 0, 1, 1));
    for (int i = 0; i < 29; i++) step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock1_tl1 got=%h want=%h", o, e); end
    exp_q.push_back(pk(0, 0, 0, 0, 1, 0));
    step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock1_exit got=%h want=%h", o, e); end
  endtask

  task automatic test_escalation();
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    exp_q.push_back(pk(1, 0, 1, 0, 2, 60));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock2_entry got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 0, 2, 0));
    for (int i = 0; i < 60; i++) step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock2_exit got=%h want=%h", o, e); end
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    exp_q.push_back(pk(1, 0, 1, 0, 3, 120));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock3_entry got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 0, 3, 0));
    for (int i = 0; i < 120; i++) step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lock3_exit got=%h want=%h", o, e); end
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    exp_q.push_back(pk(1, 1, 1, 0, 4, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL blocked_entry got=%h want=%h", o, e); end
    exp_q.push_back(pk(1, 1, 0, 0, 4, 0));
    step(0, 0, 0, 1); step(1, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL blocked_ignore got=%h want=%h", o, e); end
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(0, 0, 1, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL admin_clear got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_held_and_locked();
    obs_t o, e;
    exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL held_first got=%h want=%h", o, e); end
    exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL held_10 got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    exp_q.push_back(pk(1, 0, 1, 0, 1, 30));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL held_lock got=%h want=%h", o, e); end
    exp_q.push_back(pk(1, 0, 0, 0, 1, 30));
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL locked_ignore got=%h want=%h", o, e); end
    exp_q.push_back(pk(1, 0, 0, 0, 1, 17));
    for (int i = 0; i < 13; i++) step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL tl17 got=%h want=%h", o, e); end
    rst_in = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 1);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL rst_midlock got=%h want=%h", o, e); end
    rst_in = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL armed_after_rst got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    obs_t o, e;
    exp_q.push_back(pk(0, 0, 0, 2, 0, 0));
    step(1, 0, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL pre_simul got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(1, 1, 0, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL simul_err_ok got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step(1, 0, 1, 0);
    e = exp_q.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL clear_wins got=%h want=%h", o, e); end
    step(0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    bus.err_in = 1'b0; bus.ok_in = 1'b0; bus.admin_clear = 1'b0; bus.tick = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_lockout();
    test_escalation();
    test_held_and_locked();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
